shift_register_ctrl: RTL and testbench
======================================

Name: shift_register_ctrl

Overview:
Full-duplex serial transfer controller built around an internal, enable-gated shift datapath. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on o_Sout at a programmable bit rate. On the same bit ticks it captures i_Sin into a receive register. When the frame completes it presents the received word on o_Qout with a one-cycle done strobe. It is the sequencing layer the team places in front of serial-to-parallel and parallel-to-serial links.

Parameters:
- BW_DATA, 8: word width in bits; must be ≥ 2.
- CLK_DIV, 4: clock cycles per serial bit; must be ≥ 1 (1 means one bit per clock).

Ports:
- i_Clk, input, 1: system clock; all state updates on the rising edge.
- i_Rst, input, 1: asynchronous reset, active-high.
- i_D, input, BW_DATA: parallel word to transmit.
- i_Valid, input, 1: i_D is valid.
- o_Ready, output, 1: controller can accept a word.
- i_Abort, input, 1: synchronous abort of the current frame.
- i_Sin, input, 1: serial receive input.
- o_Sout, output, 1: serial transmit output, MSB first.
- o_Tick, output, 1: bit-strobe; high in the cycle where a bit is sampled and shifted.
- o_Busy, output, 1: frame in progress.
- o_Qout, output, BW_DATA: last completed received word.
- o_Done, output, 1: one-cycle pulse; o_Qout has been updated.

Behaviour:
- Reset (i_Rst=1, asynchronous) forces the following, regardless of state:
  - state = IDLE
  - tx_reg = 0, rx_reg = 0, o_Qout = 0
  - bit_cnt = 0, div_cnt = 0
  - o_Sout = 0, o_Tick = 0, o_Busy = 0, o_Done = 0, o_Ready = 1
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_Ready = 1, o_Busy = 0, o_Sout = 0.
  - If i_Valid=1 at a rising edge: tx_reg <= i_D, rx_reg <= 0, bit_cnt <= 0, div_cnt <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - o_Ready = 0, o_Busy = 1, o_Sout = tx_reg[BW_DATA-1] (held stable for the whole bit period).
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - o_Tick = 1 combinationally when div_cnt == CLK_DIV-1.
  - On a tick edge:
    - rx_reg <= {rx_reg[BW_DATA-2:0], i_Sin}
    - tx_reg <= {tx_reg[BW_DATA-2:0], 1'b0}
    - bit_cnt <= bit_cnt+1
    - if bit_cnt == BW_DATA-1: o_Qout <= {rx_reg[BW_DATA-2:0], i_Sin} and go to DONE.
- DONE:
  - Lasts exactly one cycle: o_Done = 1, o_Busy = 1, o_Ready = 0, o_Sout = 0; then go to IDLE.
- Handshake:
  - A word transfers only when i_Valid && o_Ready at a rising edge.
  - i_Valid while o_Ready=0 is ignored. It is not queued, and i_D must be held by the source.
  - Earliest next accept is the IDLE cycle following DONE, i.e. 2 cycles after the last tick.
- Latency:
  - Accept edge at cycle 0 → SHIFT during cycles 1..BW_DATA*CLK_DIV → o_Done high in cycle BW_DATA*CLK_DIV+1.
  - Defaults: SHIFT for 32 cycles, o_Done in cycle 33.
  - i_Sin is sampled at the last cycle of each bit period, so bit k (MSB first) is sampled at cycle (k+1)*CLK_DIV.
- Abort:
  - i_Abort=1 in SHIFT or DONE → next edge goes to IDLE and clears tx_reg, bit_cnt, div_cnt.
  - o_Qout is unchanged and o_Done is not asserted. If abort coincides with the final tick, abort wins.
  - i_Abort in IDLE has no effect, and abort has priority over an accept in the same cycle.
- Reset mid-frame: immediate return to the reset values; no o_Done.
- Widths:
  - bit_cnt is $clog2(BW_DATA)+1 bits and div_cnt is $clog2(CLK_DIV)+1 bits; neither ever exceeds its terminal value.
  - With CLK_DIV=1, div_cnt stays 0 and o_Tick = 1 in every SHIFT cycle.

Test Plan:
- Reset then idle, defaults: after i_Rst pulse → o_Ready=1, o_Busy=0, o_Sout=0, o_Qout=0x00; i_Valid held low for 20 cycles → no o_Done.
- Loopback, i_Sin tied to o_Sout, i_D=0xA5 accepted at cycle 0:
  - o_Sout sequence is 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - o_Tick high at cycles 4,8,…,32.
  - o_Done high in cycle 33 only, with o_Qout=0xA5.
- Independent receive: i_D=0x00, i_Sin driven 1,1,0,0,1,0,1,1 per bit period → o_Qout=0xCB at o_Done; o_Sout=0 throughout.
- Busy rejection and back-to-back:
  - Second i_Valid with i_D=0x3C during SHIFT is ignored; the first frame completes unchanged.
  - i_Valid held high → next frame accepted in the cycle after DONE and its o_Done arrives 34 cycles after the first o_Done.
- Abort: i_Abort=1 at cycle 10 of a frame → IDLE next cycle, o_Ready=1, o_Qout keeps its previous value, no o_Done; a new frame of 0x5A then completes with o_Qout=0x5A in loopback.
- Reset mid-frame plus CLK_DIV=1 build:
  - i_Rst asserted asynchronously at cycle 13 → all outputs go to reset values immediately.
  - With CLK_DIV=1, a 0xFF loopback frame gives o_Done at cycle 9 and o_Qout=0xFF.

Source files
------------

// File: rtl/shift_register_ctrl_if.sv
// Handshake, serial and result signals of the full-duplex serial transfer controller.
// The master side supplies words and serial input; the slave side is the controller.
interface shift_register_ctrl_if #(
  parameter int unsigned BW_DATA = 8
) ();

  logic [BW_DATA-1:0] i_D;
  logic               i_Valid;
  logic               o_Ready;
  logic               i_Abort;
  logic               i_Sin;
  logic               o_Sout;
  logic               o_Tick;
  logic               o_Busy;
  logic [BW_DATA-1:0] o_Qout;
  logic               o_Done;

  modport master (
    output i_D,
    output i_Valid,
    output i_Abort,
    output i_Sin,
    input  o_Ready,
    input  o_Sout,
    input  o_Tick,
    input  o_Busy,
    input  o_Qout,
    input  o_Done
  );

  modport slave (
    input  i_D,
    input  i_Valid,
    input  i_Abort,
    input  i_Sin,
    output o_Ready,
    output o_Sout,
    output o_Tick,
    output o_Busy,
    output o_Qout,
    output o_Done
  );

endinterface

// File: rtl/shift_register_ctrl.sv
// Full-duplex serial transfer controller: shifts a parallel word out MSB-first while
// capturing i_Sin on the same bit ticks, then publishes the received word with a done strobe.
module shift_register_ctrl #(
  parameter int unsigned BW_DATA = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  shift_register_ctrl_if.slave  io_bus
);

  localparam int unsigned BW_BCNT = $clog2(BW_DATA) + 1;
  localparam int unsigned BW_DCNT = $clog2(CLK_DIV) + 1;
  localparam logic [BW_BCNT-1:0] BIT_LAST = BW_BCNT'(BW_DATA - 1);
  localparam logic [BW_DCNT-1:0] DIV_LAST = BW_DCNT'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW_DATA-1:0]   r_tx;
  logic [BW_DATA-1:0]   w_tx_nxt;
  logic [BW_DATA-1:0]   r_rx;
  logic [BW_DATA-1:0]   w_rx_nxt;
  logic [BW_DATA-1:0]   r_qout;
  logic [BW_DATA-1:0]   w_qout_nxt;
  logic [BW_BCNT-1:0]   r_bit_cnt;
  logic [BW_BCNT-1:0]   w_bit_cnt_nxt;
  logic [BW_DCNT-1:0]   r_div_cnt;
  logic [BW_DCNT-1:0]   w_div_cnt_nxt;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_last_bit;
  logic [BW_DATA-1:0]   w_tx_shift;
  logic [BW_DATA-1:0]   w_rx_shift;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_sout;
  logic                 w_done;

  // Bit strobe, frame-end detect and the enable-gated shift candidates.
  always_comb begin : p_datapath
    w_accept   = 1'b0;
    w_tick     = 1'b0;
    w_last_bit = 1'b0;
    w_tx_shift = {r_tx[BW_DATA-2:0], 1'b0};
    w_rx_shift = {r_rx[BW_DATA-2:0], io_bus.i_Sin};
    if (r_state == ST_IDLE) begin
      w_accept = io_bus.i_Valid && !io_bus.i_Abort;
    end
    if (r_state == ST_SHIFT) begin
      w_tick = (r_div_cnt == DIV_LAST);
    end
    w_last_bit = (r_bit_cnt == BIT_LAST);
  end

  // Next-state and next-register values; abort beats both tick and frame completion.
  always_comb begin : p_next
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_qout_nxt    = r_qout;
    w_bit_cnt_nxt = r_bit_cnt;
    w_div_cnt_nxt = r_div_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = ST_SHIFT;
          w_tx_nxt      = io_bus.i_D;
          w_rx_nxt      = '0;
          w_bit_cnt_nxt = '0;
          w_div_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (io_bus.i_Abort) begin
          w_state_nxt   = ST_IDLE;
          w_tx_nxt      = '0;
          w_bit_cnt_nxt = '0;
          w_div_cnt_nxt = '0;
        end else if (w_tick) begin
          w_tx_nxt      = w_tx_shift;
          w_rx_nxt      = w_rx_shift;
          w_div_cnt_nxt = '0;
          if (w_last_bit) begin
            // Counter parks at zero so it never runs past its terminal value.
            w_bit_cnt_nxt = '0;
            w_qout_nxt    = w_rx_shift;
            w_state_nxt   = ST_DONE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW_BCNT'(1);
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + BW_DCNT'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (io_bus.i_Abort) begin
          w_tx_nxt      = '0;
          w_bit_cnt_nxt = '0;
          w_div_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin : p_outputs
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_sout  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        w_sout = r_tx[BW_DATA-1];
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin : p_regs
    if (i_Rst) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_qout    <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_qout    <= w_qout_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  assign io_bus.o_Ready = w_ready;
  assign io_bus.o_Busy  = w_busy;
  assign io_bus.o_Sout  = w_sout;
  assign io_bus.o_Done  = w_done;
  assign io_bus.o_Tick  = w_tick;
  assign io_bus.o_Qout  = r_qout;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench for shift_register_ctrl: per-cycle serial/handshake checks with a
// scoreboard of expected received words; a second instance covers one bit per clock.
module tb_shift_register_ctrl;

  logic clk;
  logic rst;
  logic loop;
  logic sin_drv;
  logic [7:0] sb_q[$];
  int n_checks;
  int n_pass;

  shift_register_ctrl_if #(.BW_DATA(8)) bus ();
  shift_register_ctrl_if #(.BW_DATA(8)) bus1 ();

  shift_register_ctrl #(.BW_DATA(8), .CLK_DIV(4)) dut (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .io_bus (bus)
  );

  shift_register_ctrl #(.BW_DATA(8), .CLK_DIV(1)) dut1 (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .io_bus (bus1)
  );

  assign bus.i_Sin  = loop ? bus.o_Sout : sin_drv;
  assign bus1.i_Sin = bus1.o_Sout;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_qout(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, 32'(obs), 32'(exp));
    end
  endtask

  // One complete frame at CLK_DIV=4, checked every cycle from accept through the IDLE cycle after DONE.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] pat, input bit lb, input bit intrude);
    int b;
    loop        = lb;
    bus.i_D     = d;
    bus.i_Valid = 1'b1;
    sin_drv     = pat[7];
    sb_q.push_back(lb ? d : pat);
    for (int c = 1; c <= 34; c++) begin
      step();
      if (c == 1) bus.i_Valid = 1'b0;
      if (intrude && c == 10) begin
        bus.i_Valid = 1'b1;
        bus.i_D     = 8'h3C;
      end
      if (intrude && c == 11) bus.i_Valid = 1'b0;
      if (c <= 32) begin
        b = 7 - (c - 1) / 4;
        sin_drv = pat[b];
        chk("sout", 32'(bus.o_Sout), 32'(d[b]));
        chk("tick", 32'(bus.o_Tick), 32'((c % 4) == 0));
        chk("busy", 32'(bus.o_Busy), 32'd1);
        chk("no_done", 32'(bus.o_Done), 32'd0);
      end else if (c == 33) begin
        chk("done_hi", 32'(bus.o_Done), 32'd1);
        chk("done_ready", 32'(bus.o_Ready), 32'd0);
        chk("done_sout", 32'(bus.o_Sout), 32'd0);
        chk_qout("qout", bus.o_Qout);
      end else begin
        chk("after_ready", 32'(bus.o_Ready), 32'd1);
        chk("after_done", 32'(bus.o_Done), 32'd0);
      end
    end
  endtask

  initial begin
    int done_seen;
    int first_done;
    int cyc;
    n_checks     = 0;
    n_pass       = 0;
    loop         = 1'b1;
    sin_drv      = 1'b0;
    bus.i_D      = 8'h00;
    bus.i_Valid  = 1'b0;
    bus.i_Abort  = 1'b0;
    bus1.i_D     = 8'h00;
    bus1.i_Valid = 1'b0;
    bus1.i_Abort = 1'b0;
    rst          = 1'b1;

    // Reset and idle defaults.
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(bus.o_Ready), 32'd1);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_sout", 32'(bus.o_Sout), 32'd0);
    chk("rst_qout", 32'(bus.o_Qout), 32'h00);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.o_Done) done_seen++;
    end
    chk("idle_no_done", 32'(done_seen), 32'd0);

    // Loopback 0xA5, then independent receive with o_Sout quiet.
    run_frame(8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(8'h00, 8'hCB, 1'b0, 1'b0);

    // Busy rejection: 0x3C offered mid-frame must not disturb the frame.
    run_frame(8'hA5, 8'h00, 1'b1, 1'b1);
    step();
    chk("no_queued_accept", 32'(bus.o_Busy), 32'd0);

    // Back-to-back with i_Valid held: second o_Done exactly 34 cycles after the first.
    loop        = 1'b1;
    bus.i_D     = 8'h96;
    bus.i_Valid = 1'b1;
    sb_q.push_back(8'h96);
    sb_q.push_back(8'h96);
    done_seen  = 0;
    first_done = 0;
    cyc        = 0;
    while (done_seen < 2 && cyc < 120) begin
      step();
      cyc++;
      if (done_seen == 1 && cyc == first_done + 1) begin
        chk("b2b_ready", 32'(bus.o_Ready), 32'd1);
      end
      if (done_seen == 1 && cyc == first_done + 2) bus.i_Valid = 1'b0;
      if (bus.o_Done) begin
        done_seen++;
        chk_qout("b2b_qout", bus.o_Qout);
        if (done_seen == 1) first_done = cyc;
        else chk("b2b_spacing", 32'(cyc - first_done), 32'd34);
      end
    end
    chk("b2b_two_done", 32'(done_seen), 32'd2);
    bus.i_Valid = 1'b0;
    step();

    // Abort at cycle 10: back to IDLE, o_Qout keeps 0x96, no o_Done.
    bus.i_D     = 8'hC3;
    bus.i_Valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) bus.i_Valid = 1'b0;
    end
    bus.i_Abort = 1'b1;
    step();
    bus.i_Abort = 1'b0;
    chk("abort_ready", 32'(bus.o_Ready), 32'd1);
    chk("abort_busy", 32'(bus.o_Busy), 32'd0);
    chk("abort_qout", 32'(bus.o_Qout), 32'h96);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.o_Done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_frame(8'h5A, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset at cycle 13 of a frame.
    bus.i_D     = 8'h77;
    bus.i_Valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) bus.i_Valid = 1'b0;
    end
    chk("pre_rst_busy", 32'(bus.o_Busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.o_Ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("mid_rst_sout", 32'(bus.o_Sout), 32'd0);
    chk("mid_rst_tick", 32'(bus.o_Tick), 32'd0);
    chk("mid_rst_qout", 32'(bus.o_Qout), 32'h00);
    chk("mid_rst_done", 32'(bus.o_Done), 32'd0);
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.o_Done) done_seen++;
    end
    chk("rst_no_done", 32'(done_seen), 32'd0);

    // CLK_DIV=1 loopback of 0xFF: tick every SHIFT cycle, o_Done in cycle 9.
    bus1.i_D     = 8'hFF;
    bus1.i_Valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) bus1.i_Valid = 1'b0;
      if (c <= 8) begin
        chk("d1_tick", 32'(bus1.o_Tick), 32'd1);
        chk("d1_no_done", 32'(bus1.o_Done), 32'd0);
      end else if (c == 9) begin
        chk("d1_done", 32'(bus1.o_Done), 32'd1);
        chk("d1_qout", 32'(bus1.o_Qout), 32'hFF);
      end else begin
        chk("d1_ready", 32'(bus1.o_Ready), 32'd1);
      end
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
